delay_prod_avg: RTL and testbench

//   Downstream consumer of the power-of-2 sample delay line in the short-preamble sync path.

---
 rtl/delay_prod_avg_pkg.sv | 21 ++
 rtl/delay_prod_avg_dpram.sv | 43 ++++
 rtl/delay_prod_avg.sv | 238 +++++++++++++++++++++++
 tb/tb_delay_prod_avg.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/delay_prod_avg_pkg.sv
// ----------------------------------------------------------------------------
// delay_prod_avg_pkg
//   Shared width helpers for the short-preamble sync datapath.
//     prod_width(dw)    : width of one complex autocorrelation product part
//                         (sum of two 2*dw signed products -> 2*dw+1 bits)
//     sum_width(dw, ws) : width of the moving sum of 2^ws products
// ----------------------------------------------------------------------------
package delay_prod_avg_pkg;

    localparam int DEFAULT_DATA_WIDTH   = 16;
    localparam int DEFAULT_WINDOW_SHIFT = 4;

    function automatic int prod_width(input int dw);
        return 2 * dw + 1;
    endfunction

    function automatic int sum_width(input int dw, input int ws);
        return prod_width(dw) + ws;
    endfunction

endpackage

// File: rtl/delay_prod_avg_dpram.sv
// ----------------------------------------------------------------------------
// delay_prod_avg_dpram
//   Simple dual-port RAM used as the moving-average window store.
//   One write port, one read port, registered read (1-cycle latency).
//   A read and a write to the same address in one cycle return the old data.
//   Ports:
//     clock    in  rising-edge clock
//     we_i     in  write enable
//     waddr_i  in  write address
//     wdata_i  in  write data
//     re_i     in  read enable (rdata_o holds when low)
//     raddr_i  in  read address
//     rdata_o  out read data, valid the cycle after re_i
// ----------------------------------------------------------------------------
module delay_prod_avg_dpram #(
    parameter int DATA_WIDTH    = 66,
    parameter int ADDRESS_WIDTH = 4
) (
    input  logic                     clock,
    input  logic                     we_i,
    input  logic [ADDRESS_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0]    wdata_i,
    input  logic                     re_i,
    input  logic [ADDRESS_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0]    rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDRESS_WIDTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Storage array and registered read port; contents need no reset.
    always_ff @(posedge clock) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/delay_prod_avg.sv
// ----------------------------------------------------------------------------
// delay_prod_avg
//   Delayed autocorrelation s[n]*conj(s[n-D]) with a moving average over
//   2^WINDOW_SHIFT products, for STF plateau detection in sync_short.
//   Ports:
//     clock, reset          rising-edge clock, async active-high reset
//     enable                0 freezes all state and forces output_strobe low
//     sample_in/_strobe     current sample {I,Q}; captured on strobe
//     delayed_in/_strobe    delay-line output, one cycle after its sample
//     avg_i, avg_q          windowed average (signed, PW = 2*DW+1 bits);
//                           updated only when a strobe is produced
//     output_strobe         one-cycle valid pulse, 3 cycles after
//                           delayed_strobe (4 with the magnitude option)
//     align_err             sticky: delayed_strobe without sample_strobe on
//                           the previous enabled cycle
//     avg_mag               (DELAY_PROD_AVG_MAG_EN only)
//                           max(|i|,|q|) + min(|i|,|q|)/2 of the average
//   Build option: define DELAY_PROD_AVG_MAG_EN for the avg_mag output.
// ----------------------------------------------------------------------------
module delay_prod_avg
    import delay_prod_avg_pkg::*;
#(
    parameter  int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter  int WINDOW_SHIFT = DEFAULT_WINDOW_SHIFT,
    localparam int PW           = prod_width(DATA_WIDTH)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [2*DATA_WIDTH-1:0] sample_in,
    input  logic                    sample_strobe,
    input  logic [2*DATA_WIDTH-1:0] delayed_in,
    input  logic                    delayed_strobe,
    output logic [PW-1:0]           avg_i,
    output logic [PW-1:0]           avg_q,
    output logic                    output_strobe,
`ifdef DELAY_PROD_AVG_MAG_EN
    output logic [PW-1:0]           avg_mag,
`endif
    output logic                    align_err
);

    localparam int DW = DATA_WIDTH;
    localparam int WS = WINDOW_SHIFT;
    localparam int MW = 2 * DW;
    localparam int SW = sum_width(DATA_WIDTH, WINDOW_SHIFT);
    localparam logic [WS:0] FILL_LAST = (WS+1)'(2**WS - 1);

    // input capture and stage 1
    logic signed [DW-1:0] cur_i_q, cur_q_q;
    logic                 ss_d1_q, align_err_q, v1_q;
    logic signed [MW-1:0] p_ii_q, p_qq_q, p_qi_q, p_iq_q;
    logic signed [DW-1:0] del_i_s, del_q_s;
    // stage 2
    logic [WS-1:0]        waddr_q, addr2_q;
    logic                 v2_q;
    logic signed [PW-1:0] prod_re_q, prod_im_q;
    // stage 3
    logic [WS:0]          fill_q, fill_d;
    logic signed [SW-1:0] sum_re_q, sum_im_q, sum_re_d, sum_im_d;
    logic signed [PW-1:0] old_re_s, old_im_s;
    logic signed [PW-1:0] avg_re_q, avg_im_q;
    logic                 strobe_q, strobe_d;
    logic [2*PW-1:0]      rdata_s;

    assign del_i_s = delayed_in[2*DW-1:DW];
    assign del_q_s = delayed_in[DW-1:0];

    // Capture current sample, alignment monitor and the four partial products.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cur_i_q     <= '0;
            cur_q_q     <= '0;
            ss_d1_q     <= 1'b0;
            align_err_q <= 1'b0;
            v1_q        <= 1'b0;
            p_ii_q      <= '0;
            p_qq_q      <= '0;
            p_qi_q      <= '0;
            p_iq_q      <= '0;
        end else if (enable) begin
            if (sample_strobe) begin
                cur_i_q <= sample_in[2*DW-1:DW];
                cur_q_q <= sample_in[DW-1:0];
            end
            ss_d1_q <= sample_strobe;
            if (delayed_strobe && !ss_d1_q) begin
                align_err_q <= 1'b1;
            end
            v1_q <= delayed_strobe;
            // The product uses cur before this cycle's capture: delayed_in
            // lags its matching sample_in by one cycle.
            if (delayed_strobe) begin
                p_ii_q <= MW'(cur_i_q) * MW'(del_i_s);
                p_qq_q <= MW'(cur_q_q) * MW'(del_q_s);
                p_qi_q <= MW'(cur_q_q) * MW'(del_i_s);
                p_iq_q <= MW'(cur_i_q) * MW'(del_q_s);
            end
        end
    end

    // Stage 2: combine partial products; claim the window slot whose read is
    // issued this cycle, so back-to-back products never share an address.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            waddr_q   <= '0;
            addr2_q   <= '0;
            v2_q      <= 1'b0;
            prod_re_q <= '0;
            prod_im_q <= '0;
        end else if (enable) begin
            v2_q <= v1_q;
            if (v1_q) begin
                addr2_q   <= waddr_q;
                waddr_q   <= waddr_q + WS'(1);
                prod_re_q <= PW'(p_ii_q) + PW'(p_qq_q);
                prod_im_q <= PW'(p_qi_q) - PW'(p_iq_q);
            end
        end
    end

    delay_prod_avg_dpram #(
        .DATA_WIDTH    (2 * PW),
        .ADDRESS_WIDTH (WS)
    ) u_window (
        .clock   (clock),
        .we_i    (enable && v2_q),
        .waddr_i (addr2_q),
        .wdata_i ({prod_re_q, prod_im_q}),
        .re_i    (enable && v1_q),
        .raddr_i (waddr_q),
        .rdata_o (rdata_s)
    );

    // Stage 3 next state: evicted product (zero until the window has filled),
    // running sum, saturating fill count and strobe qualification.
    always_comb begin
        old_re_s = '0;
        old_im_s = '0;
        fill_d   = fill_q;
        if (fill_q[WS]) begin
            old_re_s = rdata_s[2*PW-1:PW];
            old_im_s = rdata_s[PW-1:0];
            fill_d   = fill_q;
        end else begin
            old_re_s = '0;
            old_im_s = '0;
            fill_d   = fill_q + (WS+1)'(1);
        end
        sum_re_d = sum_re_q + SW'(prod_re_q) - SW'(old_re_s);
        sum_im_d = sum_im_q + SW'(prod_im_q) - SW'(old_im_s);
        strobe_d = v2_q && (fill_q >= FILL_LAST);
    end

    // Stage 3 registers: sum, fill, average and strobe.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fill_q   <= '0;
            sum_re_q <= '0;
            sum_im_q <= '0;
            avg_re_q <= '0;
            avg_im_q <= '0;
            strobe_q <= 1'b0;
        end else if (enable) begin
            strobe_q <= strobe_d;
            if (v2_q) begin
                fill_q   <= fill_d;
                sum_re_q <= sum_re_d;
                sum_im_q <= sum_im_d;
            end
            // Dropping the low WS bits of the sum is the floor division by
            // the window length; the remaining PW bits cannot overflow.
            if (strobe_d) begin
                avg_re_q <= sum_re_d[SW-1:WS];
                avg_im_q <= sum_im_d[SW-1:WS];
            end
        end
    end

    assign align_err = align_err_q;

`ifdef DELAY_PROD_AVG_MAG_EN
    logic [PW-1:0] abs_i_s, abs_q_s, max_s, min_s, mag_s;
    logic [PW-1:0] out_i_q, out_q_q, mag_q;
    logic          out_strobe_q;

    // Magnitude approximation of the stage-3 average.
    always_comb begin
        abs_i_s = avg_re_q;
        abs_q_s = avg_im_q;
        if (avg_re_q[PW-1]) begin
            abs_i_s = -avg_re_q;
        end else begin
            abs_i_s = avg_re_q;
        end
        if (avg_im_q[PW-1]) begin
            abs_q_s = -avg_im_q;
        end else begin
            abs_q_s = avg_im_q;
        end
        if (abs_i_s >= abs_q_s) begin
            max_s = abs_i_s;
            min_s = abs_q_s;
        end else begin
            max_s = abs_q_s;
            min_s = abs_i_s;
        end
        mag_s = max_s + (min_s >> 1);
    end

    // Output stage keeping average, magnitude and strobe aligned.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_i_q      <= '0;
            out_q_q      <= '0;
            mag_q        <= '0;
            out_strobe_q <= 1'b0;
        end else if (enable) begin
            out_strobe_q <= strobe_q;
            if (strobe_q) begin
                out_i_q <= avg_re_q;
                out_q_q <= avg_im_q;
                mag_q   <= mag_s;
            end
        end
    end

    assign avg_i         = out_i_q;
    assign avg_q         = out_q_q;
    assign avg_mag       = mag_q;
    assign output_strobe = out_strobe_q && enable;
`else
    assign avg_i         = avg_re_q;
    assign avg_q         = avg_im_q;
    assign output_strobe = strobe_q && enable;
`endif

endmodule

// File: tb/tb_delay_prod_avg.sv
// ----------------------------------------------------------------------------
// tb_delay_prod_avg
//   Directed stimulus for delay_prod_avg with a window-of-products reference
//   model and literal spot checks. Build with DELAY_PROD_AVG_MAG_EN to cover
//   the avg_mag output and the longer latency.
// ----------------------------------------------------------------------------
module tb_delay_prod_avg;

    localparam int DW  = 16;
    localparam int WS  = 4;
    localparam int PW  = 2 * DW + 1;
    localparam int WIN = 16;
`ifdef DELAY_PROD_AVG_MAG_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic [2*DW-1:0] sample_in = '0;
    logic          sample_strobe = 1'b0;
    logic [2*DW-1:0] delayed_in = '0;
    logic          delayed_strobe = 1'b0;
    logic [PW-1:0] avg_i, avg_q;
    logic          output_strobe, align_err;
`ifdef DELAY_PROD_AVG_MAG_EN
    logic [PW-1:0] avg_mag;
`endif

    always #5 clock = ~clock;

    delay_prod_avg #(.DATA_WIDTH(DW), .WINDOW_SHIFT(WS)) dut (
        .clock          (clock),
        .reset          (reset),
        .enable         (enable),
        .sample_in      (sample_in),
        .sample_strobe  (sample_strobe),
        .delayed_in     (delayed_in),
        .delayed_strobe (delayed_strobe),
        .avg_i          (avg_i),
        .avg_q          (avg_q),
        .output_strobe  (output_strobe),
`ifdef DELAY_PROD_AVG_MAG_EN
        .avg_mag        (avg_mag),
`endif
        .align_err      (align_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int     due;
        longint ai;
        longint aq;
    } ev_t;

    longint m_cur_i, m_cur_q;
    bit     m_ss_prev;
    longint win_re[$];
    longint win_im[$];
    int     m_nprod;
    ev_t    evq[$];
    int     en_idx = 0;
    bit     m_str;
    longint m_avg_i, m_avg_q;
    bit     m_align;
    int     strobe_seen = 0;

    function automatic void model_clear();
        m_cur_i = 0; m_cur_q = 0; m_ss_prev = 1'b0;
        win_re.delete(); win_im.delete(); evq.delete();
        m_nprod = 0; m_str = 1'b0; m_avg_i = 0; m_avg_q = 0; m_align = 1'b0;
    endfunction

    initial begin : model
        longint di, dq, pr, pi, sr, si;
        model_clear();
        forever begin
            @(posedge clock or posedge reset);
            if (reset) begin
                model_clear();
            end else if (enable) begin
                en_idx++;
                if (delayed_strobe) begin
                    di = longint'($signed(delayed_in[2*DW-1:DW]));
                    dq = longint'($signed(delayed_in[DW-1:0]));
                    // s * conj(d)
                    pr = m_cur_i * di + m_cur_q * dq;
                    pi = m_cur_q * di - m_cur_i * dq;
                    if (!m_ss_prev) m_align = 1'b1;
                    win_re.push_back(pr);
                    win_im.push_back(pi);
                    if (win_re.size() > WIN) begin
                        void'(win_re.pop_front());
                        void'(win_im.pop_front());
                    end
                    m_nprod++;
                    if (m_nprod >= WIN) begin
                        sr = 0; si = 0;
                        foreach (win_re[k]) begin
                            sr += win_re[k];
                            si += win_im[k];
                        end
                        evq.push_back('{en_idx + LAT - 1, sr >>> WS, si >>> WS});
                    end
                end
                if (sample_strobe) begin
                    m_cur_i = longint'($signed(sample_in[2*DW-1:DW]));
                    m_cur_q = longint'($signed(sample_in[DW-1:0]));
                end
                m_ss_prev = sample_strobe;
                if (evq.size() > 0 && evq[0].due == en_idx) begin
                    m_str   = 1'b1;
                    m_avg_i = evq[0].ai;
                    m_avg_q = evq[0].aq;
                    void'(evq.pop_front());
                end else begin
                    m_str = 1'b0;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin : compare
        longint ai, aq, mx, mn;
        forever begin
            @(negedge clock);
            check("strobe", longint'(output_strobe), longint'(m_str && enable));
            check("avg_i", longint'($signed(avg_i)), m_avg_i);
            check("avg_q", longint'($signed(avg_q)), m_avg_q);
            check("align_err", longint'(align_err), longint'(m_align));
`ifdef DELAY_PROD_AVG_MAG_EN
            ai = (m_avg_i < 0) ? -m_avg_i : m_avg_i;
            aq = (m_avg_q < 0) ? -m_avg_q : m_avg_q;
            mx = (ai >= aq) ? ai : aq;
            mn = (ai >= aq) ? aq : ai;
            check("avg_mag", longint'(avg_mag), mx + (mn >> 1));
`endif
            if (output_strobe) strobe_seen++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit ss, input int si, input int sq,
                         input bit ds, input int di, input int dq, input bit en);
        sample_strobe  = ss;
        sample_in      = {16'(si), 16'(sq)};
        delayed_strobe = ds;
        delayed_in     = {16'(di), 16'(dq)};
        enable         = en;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 0, 0, 1'b0, 0, 0, 1'b1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
    endtask

    // One priming sample, then n cycles each carrying a sample and a product.
    task automatic stream(input int n, input int si, input int sq, input int di, input int dq);
        drive(1'b1, si, sq, 1'b0, 0, 0, 1'b1);
        repeat (n) drive(1'b1, si, sq, 1'b1, di, dq, 1'b1);
    endtask

    initial begin : stim
        int base;
        do_reset();
        check("reset_avg_i", longint'($signed(avg_i)), 0);
        check("reset_strobe", longint'(output_strobe), 0);
        check("reset_align", longint'(align_err), 0);

        // 1: fill behaviour and latency
        base = strobe_seen;
        stream(16, 1000, 0, 1000, 0);
        idle(LAT - 1);
        check("t1_no_early_strobe", longint'(strobe_seen - base), 0);
        check("t1_strobe_at_lat", longint'(output_strobe), 1);
        check("t1_avg_i", longint'($signed(avg_i)), 1000000);
        check("t1_avg_q", longint'($signed(avg_q)), 0);
        idle(3);
        check("t1_one_strobe", longint'(strobe_seen - base), 1);

        // 2: quadrature
        stream(17, 0, 1000, 1000, 0);
        idle(LAT + 1);
        check("t2_avg_i", longint'($signed(avg_i)), 0);
        check("t2_avg_q", longint'($signed(avg_q)), 1000000);

        // 3: full-scale negative inputs
        do_reset();
        stream(17, -32768, -32768, -32768, -32768);
        idle(LAT + 1);
        check("t3_avg_i", longint'($signed(avg_i)), 64'sd2147483648);
        check("t3_avg_q", longint'($signed(avg_q)), 0);

        // 4: +1 window stepping down to -1 (floor on mixed sums)
        do_reset();
        stream(16, 1, 0, 1, 0);
        repeat (16) drive(1'b1, 1, 0, 1'b1, -1, 0, 1'b1);
        idle(LAT + 1);
        check("t4_avg_i", longint'($signed(avg_i)), -1);

        // 5: alignment error is sticky until reset
        do_reset();
        drive(1'b0, 0, 0, 1'b1, 5, 5, 1'b1);
        idle(2);
        check("t5_align_set", longint'(align_err), 1);
        idle(5);
        check("t5_align_held", longint'(align_err), 1);
        do_reset();
        check("t5_align_cleared", longint'(align_err), 0);

        // 6: freeze with strobes in flight, then reset mid-window
        stream(17, 3, 4, 2, 1);
        repeat (5) drive(1'b1, 7, 7, 1'b1, 7, 7, 1'b0);
        repeat (5) drive(1'b1, 3, 4, 1'b1, 2, 1, 1'b1);
        do_reset();
        base = strobe_seen;
        stream(15, 3, 4, 2, 1);
        repeat (LAT + 1) drive(1'b1, 3, 4, 1'b0, 0, 0, 1'b1);
        check("t6_no_strobe_15", longint'(strobe_seen - base), 0);
        drive(1'b1, 3, 4, 1'b1, 2, 1, 1'b1);
        idle(LAT + 1);
        check("t6_strobe_16", longint'(strobe_seen - base), 1);

        // magnitude case: avg = (300,-400)
        do_reset();
        stream(16, 300, -400, 1, 0);
        idle(LAT + 1);
        check("t6_avg_i", longint'($signed(avg_i)), 300);
        check("t6_avg_q", longint'($signed(avg_q)), -400);
`ifdef DELAY_PROD_AVG_MAG_EN
        check("t6_avg_mag", longint'(avg_mag), 550);
`endif
        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
